enc_ctrl_multi: RTL
===================

// Module: enc_ctrl_multi
// PURPOSE
//  Parametrised multi-channel quadrature encoder controller; successor to the fixed 24-bit
//  controller. Per channel: sync + debounce of A/B/I, quadrature decode, CNT_WIDTH counter with
//  preload and sticky overflow, illegal-transition counter, and synchronous index capture
//  with selectable mode. Sits behind the main register file; read mux selected by channel.
// PARAMETERS
//  NUM_ENC     4          channels, 1..15; channel numbers are 1-based (1..NUM_ENC)
//  CNT_WIDTH   24         position counter width, 8..26
//  DEB_CYCLES  4          consecutive stable cycles before A/B filter output changes, 1..255
//  IDX_DEB     3          same, for index line
//  RESET_CNT   1<<(CNT_WIDTH-1)  counter and preload value after reset (midrange)
// PORTS
//  sysclk          in   1          global clock
//  reset           in   1          synchronous, active-high
//  enc_a,enc_b,enc_i in [1:NUM_ENC] raw encoder lines, asynchronous
//  reg_raddr_chan  in   4          read channel select
//  reg_waddr       in   16         write address: [15:12] block, [7:4] channel, [3:0] offset
//  reg_wdata       in   32         write data
//  reg_wen         in   1          write strobe, one cycle
//  reg_preload     out  32         {0, preload[CNT_WIDTH-1:0]}
//  reg_quad_data   out  32         [31]ovf [30:28]{i,b,a} filtered [27]dir [CNT_WIDTH-1:0]count
//  reg_index_data  out  32         [31:28]idx_cnt [27]dir@latch [26]valid [CNT_WIDTH-1:0]latched
//  reg_status      out  32         [31:24]err_cnt [2]armed [1:0]idx_mode, rest 0
// BEHAVIOUR
//  - Reset: count=preload=RESET_CNT, ovf=0, dir=0, err_cnt=0, idx_cnt=0, latched=0, valid=0,
//    idx_mode=0, armed=0, sync/filter regs=0, every channel in PRIME. All outputs follow.
//  - Input path: 2-flop sync, then filter: output takes input after it has been stable for
//    DEB_CYCLES (A/B) or IDX_DEB (I) consecutive cycles. Counter inputs = filtered values.
//  - Channel FSM: PRIME -> RUN after 2+max(DEB_CYCLES,IDX_DEB) cycles. In PRIME, prev{a,b}
//    and prev_i track filtered values; no counting, no errors, no index events.
//  - Decode in RUN on {a,b} change vs prev: 00->10->11->01->00 = +1, dir=1; reverse = -1,
//    dir=0; both bits change = illegal: count/dir unchanged, err_cnt+1 saturating at 255.
//  - Count wraps mod 2^CNT_WIDTH; wrap in either direction sets ovf (sticky).
//  - Write decode: reg_wen && waddr[15:12]==ADDR_MAIN && chan in 1..NUM_ENC; others ignored.
//    OFF_ENC_LOAD: preload<=wdata, count<=wdata, ovf<=0, err_cnt<=0; visible next cycle.
//    OFF_ENC_IDX : idx_mode<=wdata[1:0], armed<=1, valid<=0, idx_cnt unchanged.
//  - Index event = filtered I rising edge in RUN; idx_cnt+1 (4-bit wrap) in all modes.
//    mode 0 OFF: no capture. mode 1 EVERY: latched<=count, valid<=1.
//    mode 2 FIRST: capture only if armed, then armed<=0. mode 3 HOME: capture as mode 1
//    and count<=preload, ovf<=0.
//  - Capture uses count as registered in the event cycle (pre-transition value).
//  - Simultaneous events, priority: LOAD write > HOME reload > quad step. The losing quad
//    step is dropped; prev still updates.
//  - Read mux is combinational from registers; reg_raddr_chan 0 or >NUM_ENC returns 0.
//  - reset asserted mid-operation: full return to reset state next edge, PRIME restarts.
// STRUCTURE
//  - Shared constants include: ADDR_MAIN, OFF_ENC_LOAD, OFF_ENC_IDX, IDX_OFF/EVERY/FIRST/HOME.
//  - One sub-module enc_chan (sync, filters, FSM, decode, counters, index logic) per channel,
//    in a generate loop. The top holds write decode and the read mux only.
// TESTING
//  1 reset, A/B idle high -> after PRIME count=0x800000, err_cnt=0, no step counted.
//  2 8 forward quad cycles (32 edges, spacing > DEB_CYCLES) -> count=0x800020, dir=1;
//    32 reverse edges -> 0x800000, dir=0.
//  3 load 0xFFFFFF, 1 forward edge -> count=0, ovf=1; load 0x000010 -> ovf=0,
//    count=0x000010 next cycle.
//  4 A and B toggle together 3 times -> err_cnt=3, count unchanged; glitch < DEB_CYCLES -> no effect.
//  5 mode FIRST, 3 index pulses -> idx_cnt=3, latched = count at first pulse, armed=0;
//    mode HOME, pulse -> count=preload.
//  6 LOAD write in the same cycle as index HOME and a quad step -> count=written value;
//    read chan 0/NUM_ENC+1 -> 0.

Source files
------------

// File: rtl/enc_ctrl_multi_pkg.sv
// Shared constants, types and helpers for the multi-channel quadrature encoder controller.
// Imported by the per-channel core and by the register-facing top.
package enc_ctrl_multi_pkg;

    localparam logic [3:0] ADDR_MAIN    = 4'h1;
    localparam logic [3:0] OFF_ENC_LOAD = 4'h0;
    localparam logic [3:0] OFF_ENC_IDX  = 4'h1;

    typedef enum logic [1:0] {
        IDX_OFF   = 2'd0,
        IDX_EVERY = 2'd1,
        IDX_FIRST = 2'd2,
        IDX_HOME  = 2'd3
    } idx_mode_e;

    typedef enum logic {StPrime, StRun} chan_state_e;

    function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    // Forward quadrature successor of {a,b}: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        unique case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/enc_chan.sv
// One encoder channel: input sync and debounce, prime/run FSM, quadrature decode,
// position/error/index counters and index capture.
module enc_chan
    import enc_ctrl_multi_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 24,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned IDX_DEB    = 3
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_i,
    input  logic                 load_wr,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 idx_wr,
    input  logic [1:0]           idx_wval,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] preload,
    output logic [CNT_WIDTH-1:0] latched,
    output logic                 ovf,
    output logic                 dir,
    output logic                 lat_dir,
    output logic                 valid,
    output logic                 armed,
    output logic [2:0]           filt,
    output logic [7:0]           err_cnt,
    output logic [3:0]           idx_cnt,
    output idx_mode_e            idx_mode
);

    localparam logic [CNT_WIDTH-1:0] RESET_CNT = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam int unsigned          PRIME_LEN = 2 + max_u(DEB_CYCLES, IDX_DEB);
    localparam logic [7:0]           DEB_LIM   = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]           IDX_LIM   = 8'(IDX_DEB - 1);

    // Bit order for sync/filter vectors is {i,b,a}.
    logic [2:0]           sync1_q, sync2_q, filt_q;
    logic [7:0]           deb_q [3];
    chan_state_e          state_q;
    logic [8:0]           prime_q;
    logic [1:0]           prev_ab_q;
    logic                 prev_i_q;
    logic [CNT_WIDTH-1:0] count_q, preload_q, latched_q;
    logic                 ovf_q, dir_q, lat_dir_q, valid_q, armed_q;
    logic [7:0]           err_q;
    logic [3:0]           idx_cnt_q;
    idx_mode_e            mode_q;

    logic [1:0] cur_ab;
    logic       run, illegal, step_fwd, step_rev, idx_evt, home, capture;

    always_comb begin
        cur_ab   = {filt_q[0], filt_q[1]};
        run      = (state_q == StRun);
        illegal  = run && ((cur_ab ^ prev_ab_q) == 2'b11);
        step_fwd = run && !illegal && (cur_ab != prev_ab_q) && (fwd_next(prev_ab_q) == cur_ab);
        step_rev = run && !illegal && (cur_ab != prev_ab_q) && !step_fwd;
        idx_evt  = run && filt_q[2] && !prev_i_q;
        home     = idx_evt && (mode_q == IDX_HOME);
        capture  = idx_evt && ((mode_q == IDX_EVERY) || (mode_q == IDX_HOME) ||
                               ((mode_q == IDX_FIRST) && armed_q));
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            for (int k = 0; k < 3; k++) deb_q[k] <= '0;
        end else begin
            sync1_q <= {enc_i, enc_b, enc_a};
            sync2_q <= sync1_q;
            for (int k = 0; k < 3; k++) begin
                if (sync2_q[k] == filt_q[k]) begin
                    deb_q[k] <= '0;
                end else if (deb_q[k] == ((k == 2) ? IDX_LIM : DEB_LIM)) begin
                    filt_q[k] <= sync2_q[k];
                    deb_q[k]  <= '0;
                end else begin
                    deb_q[k] <= deb_q[k] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= StPrime;
            prime_q   <= '0;
            prev_ab_q <= '0;
            prev_i_q  <= 1'b0;
            count_q   <= RESET_CNT;
            preload_q <= RESET_CNT;
            latched_q <= '0;
            ovf_q     <= 1'b0;
            dir_q     <= 1'b0;
            lat_dir_q <= 1'b0;
            valid_q   <= 1'b0;
            armed_q   <= 1'b0;
            err_q     <= '0;
            idx_cnt_q <= '0;
            mode_q    <= IDX_OFF;
        end else begin
            prev_ab_q <= cur_ab;
            prev_i_q  <= filt_q[2];
            unique case (state_q)
                StPrime: begin
                    prime_q <= prime_q + 9'd1;
                    if (prime_q == 9'(PRIME_LEN)) state_q <= StRun;
                end
                default: state_q <= StRun;
            endcase

            if (illegal && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
            if (idx_evt) idx_cnt_q <= idx_cnt_q + 4'd1;
            if (capture) begin
                latched_q <= count_q;
                lat_dir_q <= dir_q;
                valid_q   <= 1'b1;
            end
            if (idx_evt && (mode_q == IDX_FIRST)) armed_q <= 1'b0;

            // Load beats a home reload, which beats a quadrature step.
            if (load_wr) begin
                preload_q <= load_val;
                count_q   <= load_val;
                ovf_q     <= 1'b0;
                err_q     <= '0;
            end else if (home) begin
                count_q <= preload_q;
                ovf_q   <= 1'b0;
            end else if (step_fwd) begin
                count_q <= count_q + 1'b1;
                dir_q   <= 1'b1;
                if (&count_q) ovf_q <= 1'b1;
            end else if (step_rev) begin
                count_q <= count_q - 1'b1;
                dir_q   <= 1'b0;
                if (count_q == '0) ovf_q <= 1'b1;
            end

            if (idx_wr) begin
                mode_q  <= idx_mode_e'(idx_wval);
                armed_q <= 1'b1;
                valid_q <= 1'b0;
            end
        end
    end

    assign count    = count_q;
    assign preload  = preload_q;
    assign latched  = latched_q;
    assign ovf      = ovf_q;
    assign dir      = dir_q;
    assign lat_dir  = lat_dir_q;
    assign valid    = valid_q;
    assign armed    = armed_q;
    assign filt     = filt_q;
    assign err_cnt  = err_q;
    assign idx_cnt  = idx_cnt_q;
    assign idx_mode = mode_q;

endmodule

// File: rtl/enc_ctrl_multi.sv
// Multi-channel quadrature encoder controller: register write decode, one enc_chan per
// channel and a combinational read mux keyed by the 1-based channel number.
module enc_ctrl_multi
    import enc_ctrl_multi_pkg::*;
#(
    parameter int unsigned NUM_ENC    = 4,
    parameter int unsigned CNT_WIDTH  = 24,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned IDX_DEB    = 3
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [1:NUM_ENC] enc_a,
    input  logic [1:NUM_ENC] enc_b,
    input  logic [1:NUM_ENC] enc_i,
    input  logic [3:0]       reg_raddr_chan,
    input  logic [15:0]      reg_waddr,
    input  logic [31:0]      reg_wdata,
    input  logic             reg_wen,
    output logic [31:0]      reg_preload,
    output logic [31:0]      reg_quad_data,
    output logic [31:0]      reg_index_data,
    output logic [31:0]      reg_status
);

    logic [3:0] wr_chan, wr_off;
    logic       wr_hit;
    logic       unused_bits;

    assign wr_chan     = reg_waddr[7:4];
    assign wr_off      = reg_waddr[3:0];
    assign wr_hit      = reg_wen && (reg_waddr[15:12] == ADDR_MAIN) && (wr_chan != 4'd0) &&
                         ({1'b0, wr_chan} <= 5'(NUM_ENC));
    assign unused_bits = ^{reg_waddr[11:8], reg_wdata[31:CNT_WIDTH]};

    logic [CNT_WIDTH-1:0] ch_count [1:NUM_ENC];
    logic [CNT_WIDTH-1:0] ch_pre   [1:NUM_ENC];
    logic [CNT_WIDTH-1:0] ch_lat   [1:NUM_ENC];
    logic [2:0]           ch_filt  [1:NUM_ENC];
    logic [7:0]           ch_err   [1:NUM_ENC];
    logic [3:0]           ch_icnt  [1:NUM_ENC];
    idx_mode_e            ch_mode  [1:NUM_ENC];
    logic [1:NUM_ENC]     ch_ovf, ch_dir, ch_ldir, ch_valid, ch_armed;

    for (genvar c = 1; c <= NUM_ENC; c++) begin : g_chan
        enc_chan #(
            .CNT_WIDTH  (CNT_WIDTH),
            .DEB_CYCLES (DEB_CYCLES),
            .IDX_DEB    (IDX_DEB)
        ) u_chan (
            .sysclk   (sysclk),
            .reset    (reset),
            .enc_a    (enc_a[c]),
            .enc_b    (enc_b[c]),
            .enc_i    (enc_i[c]),
            .load_wr  (wr_hit && (wr_chan == 4'(c)) && (wr_off == OFF_ENC_LOAD)),
            .load_val (reg_wdata[CNT_WIDTH-1:0]),
            .idx_wr   (wr_hit && (wr_chan == 4'(c)) && (wr_off == OFF_ENC_IDX)),
            .idx_wval (reg_wdata[1:0]),
            .count    (ch_count[c]),
            .preload  (ch_pre[c]),
            .latched  (ch_lat[c]),
            .ovf      (ch_ovf[c]),
            .dir      (ch_dir[c]),
            .lat_dir  (ch_ldir[c]),
            .valid    (ch_valid[c]),
            .armed    (ch_armed[c]),
            .filt     (ch_filt[c]),
            .err_cnt  (ch_err[c]),
            .idx_cnt  (ch_icnt[c]),
            .idx_mode (ch_mode[c])
        );
    end

    always_comb begin
        reg_preload    = '0;
        reg_quad_data  = '0;
        reg_index_data = '0;
        reg_status     = '0;
        for (int c = 1; c <= int'(NUM_ENC); c++) begin
            if (reg_raddr_chan == 4'(c)) begin
                reg_preload[CNT_WIDTH-1:0]    = ch_pre[c];
                reg_quad_data[CNT_WIDTH-1:0]  = ch_count[c];
                reg_quad_data[31]             = ch_ovf[c];
                reg_quad_data[30:28]          = ch_filt[c];
                reg_quad_data[27]             = ch_dir[c];
                reg_index_data[CNT_WIDTH-1:0] = ch_lat[c];
                reg_index_data[31:28]         = ch_icnt[c];
                reg_index_data[27]            = ch_ldir[c];
                reg_index_data[26]            = ch_valid[c];
                reg_status[31:24]             = ch_err[c];
                reg_status[2]                 = ch_armed[c];
                reg_status[1:0]               = ch_mode[c];
            end
        end
    end

endmodule
